// File: rtl/pacote_es.sv
// pacote_es: shared state encoding and default widths for the I/O responder.
package pacote_es;
  localparam int LARGURA_DADOS_PAD   = 32;
  localparam int LARGURA_CHAVES_PAD  = 16;
  localparam int CICLOS_DEBOUNCE_PAD = 50000;
  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA_SOLTAR,
    ESPERA_APERTO,
    ENTREGA,
    PARADO
  } estado_es_t;
endpackage

// File: rtl/filtro_botao.sv
// filtro_botao: 2-FF synchronizer for button and switches; optional debounce
// counter when CONTROLADOR_ES_DEBOUNCE_EN is defined.
module filtro_botao #(
  parameter int LARGURA_CHAVES  = 16,
  parameter int CICLOS_DEBOUNCE = 50000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      botao,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  output logic                      botao_f,
  output logic [LARGURA_CHAVES-1:0] chaves_s
);
  logic [1:0]                botao_sinc_q;
  logic [LARGURA_CHAVES-1:0] chaves_m_q, chaves_s_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      botao_sinc_q <= '0;
      chaves_m_q   <= '0;
      chaves_s_q   <= '0;
    end else begin
      botao_sinc_q <= {botao_sinc_q[0], botao};
      chaves_m_q   <= chaves;
      chaves_s_q   <= chaves_m_q;
    end
  end
  assign chaves_s = chaves_s_q;
`ifdef CONTROLADOR_ES_DEBOUNCE_EN
  localparam int W = $clog2(CICLOS_DEBOUNCE + 1);
  logic [W-1:0] cont_q, cont_d;
  logic         botao_f_q, botao_f_d, difere, fim;
  // Counting only while the input disagrees with the filtered value restarts it on any bounce.
  always_comb begin
    difere    = botao_sinc_q[1] != botao_f_q;
    fim       = cont_q == W'(CICLOS_DEBOUNCE - 1);
    cont_d    = (difere && !fim) ? cont_q + 1'b1 : '0;
    botao_f_d = (difere && fim) ? botao_sinc_q[1] : botao_f_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_q    <= '0;
      botao_f_q <= 1'b0;
    end else begin
      cont_q    <= cont_d;
      botao_f_q <= botao_f_d;
    end
  end
  assign botao_f = botao_f_q;
`else
  assign botao_f = botao_sinc_q[1];
`endif
endmodule

// File: rtl/controlador_es.sv
// controlador_es: in/out/halt responder beside the datapath; stalls on `in`,
// latches `out`, freezes on `halt`. Debounce via CONTROLADOR_ES_DEBOUNCE_EN.
module controlador_es
  import pacote_es::*;
#(
  parameter int LARGURA_DADOS   = LARGURA_DADOS_PAD,
  parameter int LARGURA_CHAVES  = LARGURA_CHAVES_PAD,
  parameter int CICLOS_DEBOUNCE = CICLOS_DEBOUNCE_PAD
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      OpIn,
  input  logic                      OpOut,
  input  logic                      OpHalt,
  input  logic [LARGURA_DADOS-1:0]  dado_saida,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic                      botao,
  output logic [LARGURA_DADOS-1:0]  dado_entrada,
  output logic                      pausa,
  output logic [LARGURA_DADOS-1:0]  display,
  output logic [7:0]                contador_saidas,
  output logic                      led_espera,
  output logic                      parado
);
  estado_es_t                estado_q, estado_d;
  logic [LARGURA_DADOS-1:0]  dado_q, dado_d, display_q, display_d;
  logic [7:0]                cont_q, cont_d;
  logic                      botao_f;
  logic [LARGURA_CHAVES-1:0] chaves_s;
  filtro_botao #(
    .LARGURA_CHAVES (LARGURA_CHAVES),
    .CICLOS_DEBOUNCE(CICLOS_DEBOUNCE)
  ) u_filtro (
    .clock   (clock),
    .reset_n (reset_n),
    .botao   (botao),
    .chaves  (chaves),
    .botao_f (botao_f),
    .chaves_s(chaves_s)
  );
  always_comb begin
    estado_d  = estado_q;
    dado_d    = dado_q;
    display_d = display_q;
    cont_d    = cont_q;
    case (estado_q)
      OCIOSO: begin
        if (OpHalt) estado_d = PARADO;
        else if (OpIn) estado_d = ESPERA_SOLTAR;
        else if (OpOut) begin
          display_d = dado_saida;
          cont_d    = cont_q + 8'd1;
        end
      end
      ESPERA_SOLTAR: estado_d = botao_f ? ESPERA_SOLTAR : ESPERA_APERTO;
      ESPERA_APERTO: begin
        if (botao_f) begin
          dado_d   = LARGURA_DADOS'(chaves_s);
          estado_d = ENTREGA;
        end
      end
      ENTREGA: estado_d = OCIOSO;
      default: estado_d = PARADO;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q  <= OCIOSO;
      dado_q    <= '0;
      display_q <= '0;
      cont_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      dado_q    <= dado_d;
      display_q <= display_d;
      cont_q    <= cont_d;
    end
  end
  assign pausa = (estado_q == OCIOSO && (OpIn || OpHalt)) || estado_q == ESPERA_SOLTAR ||
                 estado_q == ESPERA_APERTO || estado_q == PARADO;
  assign led_espera      = estado_q == ESPERA_SOLTAR || estado_q == ESPERA_APERTO;
  assign parado          = estado_q == PARADO;
  assign dado_entrada    = dado_q;
  assign display         = display_q;
  assign contador_saidas = cont_q;
endmodule
